uart_rx_fifo: RTL and testbench

//  UART receiver (8N1, LSB first) with a show-ahead byte FIFO. Feeds the datapath's

---
 rtl/uart_rx_fifo.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver (LSB first) feeding a show-ahead byte FIFO.
// Head byte is registered and moves on the same edge as the read pointer.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   input  logic              rdreq,
   output logic [7:0]        data_out,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              frame_err,
   output logic              overflow
);

   localparam int TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [TW-1:0]   T_FULL   = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0]   T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT
   } state_e;

   state_e            state_q, state_d;
   logic              rx_meta_q, rx_s_q;
   logic [TW-1:0]     timer_q, timer_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              ferr_q;

   logic              timer_clr, sample_bit, push, ferr;
   logic              half_hit, bit_hit;

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [7:0]        data_q, data_d;
   logic              ovf_q, ovf_d;
   logic              empty_w, full_w, do_pop, do_push;

   assign half_hit = (timer_q == T_HALF);
   assign bit_hit  = (timer_q == T_FULL);

   // Two-flop synchroniser; idle-high so reset reads as line idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Receiver state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Receiver next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (!rx_s_q) state_d = S_START;
         S_START: if (half_hit) state_d = rx_s_q ? S_IDLE : S_DATA;
         S_DATA:  if (bit_hit && idx_q == 3'd7) state_d = S_STOP;
         S_STOP:  if (bit_hit) state_d = S_WAIT;
         S_WAIT:  if (rx_s_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Receiver per-state control strobes
   always_comb begin
      timer_clr  = 1'b0;
      sample_bit = 1'b0;
      push       = 1'b0;
      ferr       = 1'b0;
      unique case (state_q)
         S_IDLE:  timer_clr = 1'b1;
         S_START: timer_clr = half_hit;
         S_DATA: begin
            timer_clr  = bit_hit;
            sample_bit = bit_hit;
         end
         S_STOP: begin
            timer_clr = bit_hit;
            push      = bit_hit & rx_s_q;
            ferr      = bit_hit & ~rx_s_q;
         end
         S_WAIT:  timer_clr = 1'b1;
         default: timer_clr = 1'b1;
      endcase
   end

   // Bit timer, bit index and shift register next values
   always_comb begin
      timer_d = timer_clr ? '0 : timer_q + 1'b1;
      idx_d   = (state_q == S_DATA) ? idx_q + 3'(sample_bit) : 3'd0;
      shift_d = shift_q;
      if (sample_bit) shift_d[idx_q] = rx_s_q;
   end

   // Receiver datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         ferr_q  <= 1'b0;
      end else begin
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         ferr_q  <= ferr;
      end
   end

   // FIFO control: a pop frees the slot a full-FIFO push needs
   always_comb begin
      empty_w = (count_q == '0);
      full_w  = (count_q == FULL_CNT);
      do_pop  = rdreq & ~empty_w;
      do_push = push & (~full_w | do_pop);
      ovf_d   = ovf_q | (push & full_w & ~rdreq);
      rd_d    = rd_q + ADDR_W'(do_pop);
      wr_d    = wr_q + ADDR_W'(do_push);
      count_d = count_q + (ADDR_W + 1)'(do_push)
              - (ADDR_W + 1)'(do_pop);
      data_d  = data_q;
      if (count_d != '0) begin
         if (do_push && rd_d == wr_q) data_d = shift_q;
         else                         data_d = mem_q[rd_d];
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= shift_q;
   end

   // FIFO pointers, count, head byte and sticky overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_out  = data_q;
   assign empty     = empty_w;
   assign full      = full_w;
   assign count     = count_q;
   assign frame_err = ferr_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with 8 clocks per bit and a 4-deep FIFO.
// Each scenario task drives the line and checks outputs inline.
module tb_uart_rx_fifo;

   localparam int CPB = 8;
   localparam int AW  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx;
   logic          rdreq;
   logic [7:0]    data_out;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          frame_err;
   logic          overflow;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .ADDR_W       (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rdreq     (rdreq),
      .data_out  (data_out),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Count cycles on which frame_err is seen high
   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One 8N1 frame; optional rdreq on the cycle the byte is pushed
   task automatic send_byte(input logic [7:0] b, input logic stop,
                            input logic rd_push, output logic mid_empty);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop;
      mid_empty = 1'bx;
      for (int j = 1; j <= CPB; j++) begin
         tick(1);
         if (j == CPB / 2) mid_empty = empty;
         rdreq = (rd_push && j == CPB - 2);
      end
      rdreq = 1'b0;
      rx = 1'b1;
   endtask

   task automatic pop();
      rdreq = 1'b1;
      tick(1);
      rdreq = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx    = 1'b1;
      rdreq = 1'b0;
      tick(3);
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL reset_flags: empty=%b full=%b count=%0d want 1 0 0",
                  empty, full, count);
      end
      checks++;
      if (data_out !== 8'h00 || frame_err !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: data_out=%h fe=%b ovf=%b want 00 0 0",
                  data_out, frame_err, overflow);
      end
      reset = 1'b1;
      tick(3);
   endtask

   task automatic test_single();
      logic m;
      send_byte(8'hA5, 1'b1, 1'b0, m);
      checks++;
      if (m !== 1'b1) begin
         errors++;
         $display("FAIL single_early: empty=%b mid-stop want 1", m);
      end
      checks++;
      if (empty !== 1'b0 || data_out !== 8'hA5 || count !== 3'd1) begin
         errors++;
         $display("FAIL single_rx: empty=%b data=%h count=%0d want 0 a5 1",
                  empty, data_out, count);
      end
      pop();
      checks++;
      if (empty !== 1'b1 || count !== 3'd0) begin
         errors++;
         $display("FAIL single_pop: empty=%b count=%0d want 1 0",
                  empty, count);
      end
      pop();
      checks++;
      if (empty !== 1'b1 || count !== 3'd0) begin
         errors++;
         $display("FAIL underflow: empty=%b count=%0d want 1 0",
                  empty, count);
      end
      send_byte(8'h96, 1'b1, 1'b1, m);
      checks++;
      if (empty !== 1'b0 || data_out !== 8'h96 || count !== 3'd1) begin
         errors++;
         $display("FAIL push_empty_rd: empty=%b data=%h count=%0d want 0 96 1",
                  empty, data_out, count);
      end
      pop();
   endtask

   task automatic test_glitch();
      logic m;
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(20);
      checks++;
      if (empty !== 1'b1 || count !== 3'd0) begin
         errors++;
         $display("FAIL glitch: empty=%b count=%0d want 1 0", empty, count);
      end
      send_byte(8'h69, 1'b1, 1'b0, m);
      checks++;
      if (data_out !== 8'h69 || count !== 3'd1) begin
         errors++;
         $display("FAIL glitch_after: data=%h count=%0d want 69 1",
                  data_out, count);
      end
      pop();
   endtask

   task automatic test_frame_err();
      logic m;
      int   f0;
      f0 = fe_cnt;
      send_byte(8'h3C, 1'b0, 1'b0, m);
      tick(4);
      checks++;
      if (fe_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL frame_err_pulse: cycles=%0d want 1", fe_cnt - f0);
      end
      checks++;
      if (count !== 3'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL frame_err_drop: count=%0d empty=%b want 0 1",
                  count, empty);
      end
      f0 = fe_cnt;
      send_byte(8'h7E, 1'b1, 1'b0, m);
      checks++;
      if (data_out !== 8'h7E || count !== 3'd1 || fe_cnt != f0) begin
         errors++;
         $display("FAIL frame_err_recover: data=%h count=%0d fe=%0d want 7e 1 0",
                  data_out, count, fe_cnt - f0);
      end
      pop();
   endtask

   task automatic test_overflow();
      logic       m;
      logic [7:0] exp;
      for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1, 1'b0, m);
      checks++;
      if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL fill: full=%b count=%0d ovf=%b want 1 4 0",
                  full, count, overflow);
      end
      send_byte(8'h15, 1'b1, 1'b0, m);
      checks++;
      if (overflow !== 1'b1 || count !== 3'd4) begin
         errors++;
         $display("FAIL overflow: ovf=%b count=%0d want 1 4", overflow, count);
      end
      for (int i = 0; i < 4; i++) begin
         exp = 8'h11 + 8'(i);
         checks++;
         if (empty !== 1'b0 || data_out !== exp) begin
            errors++;
            $display("FAIL ovf_read%0d: data=%h empty=%b want %h 0",
                     i, data_out, empty, exp);
         end
         pop();
      end
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drain: empty=%b full=%b ovf=%b want 1 0 1",
                  empty, full, overflow);
      end
   endtask

   task automatic test_reset_mid();
      logic       m;
      logic [7:0] b;
      send_byte(8'h31, 1'b1, 1'b0, m);
      send_byte(8'h32, 1'b1, 1'b0, m);
      checks++;
      if (count !== 3'd2 || data_out !== 8'h31) begin
         errors++;
         $display("FAIL queued: count=%0d data=%h want 2 31", count, data_out);
      end
      b  = 8'hC3;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = b[4];
      tick(3);
      reset = 1'b0;
      #1;
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0 ||
          data_out !== 8'h00 || frame_err !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: e=%b f=%b c=%0d d=%h fe=%b ovf=%b want 1 0 0 00 0 0",
                  empty, full, count, data_out, frame_err, overflow);
      end
      rx = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(3);
      send_byte(8'h5A, 1'b1, 1'b0, m);
      checks++;
      if (data_out !== 8'h5A || count !== 3'd1) begin
         errors++;
         $display("FAIL after_reset: data=%h count=%0d want 5a 1",
                  data_out, count);
      end
      pop();
   endtask

   task automatic test_full_rw();
      logic       m;
      logic [7:0] exp;
      for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 1'b1, 1'b0, m);
      checks++;
      if (count !== 3'd4 || full !== 1'b1) begin
         errors++;
         $display("FAIL full_rw_fill: count=%0d full=%b want 4 1", count, full);
      end
      send_byte(8'h25, 1'b1, 1'b1, m);
      checks++;
      if (count !== 3'd4 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_rw: count=%0d ovf=%b want 4 0", count, overflow);
      end
      for (int i = 0; i < 4; i++) begin
         exp = 8'h22 + 8'(i);
         checks++;
         if (empty !== 1'b0 || data_out !== exp) begin
            errors++;
            $display("FAIL full_rw_read%0d: data=%h empty=%b want %h 0",
                     i, data_out, empty, exp);
         end
         pop();
      end
      checks++;
      if (empty !== 1'b1 || count !== 3'd0) begin
         errors++;
         $display("FAIL full_rw_drain: empty=%b count=%0d want 1 0",
                  empty, count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_overflow();
      test_reset_mid();
      test_full_rw();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
